hamming_stream_encoder: RTL
===========================

# hamming_stream_encoder

Streaming Hamming(7,4) encoder that sits directly upstream of the `hammingDecoder` stage. It accepts bytes on a valid/ready input and emits two 7-bit codewords per byte (low nibble first) on a valid/ready output, one codeword per cycle at full rate. An optional compile-time single-bit error injector lets the downstream decoder's correction path be exercised in-system.

## Interface
Parameters:
- `CNT_W`, 16: width of the emitted-codeword counter.

Ports:
- `clk`  input  1  rising-edge clock.
- `rst_n`  input  1  asynchronous, active-low reset.
- `in_data`  input  8  byte to encode.
- `in_valid`  input  1  `in_data` is valid.
- `in_ready`  output  1  encoder accepts `in_data` this cycle.
- `codeword`  output  7  registered codeword; layout below.
- `cw_valid`  output  1  `codeword` is valid.
- `cw_ready`  input  1  downstream consumes `codeword` this cycle.
- `cw_count`  output  CNT_W  number of codewords handed off since reset, wraps.
- `inj_pos`  input  3  error-injection bit position, 1..7; 0 = none. Present only with `HAMMING_ERR_INJECT_EN`.

## Operation
- Codeword layout, nibble d[3:0]: `codeword[0]=p1`, `[1]=p2`, `[2]=d0`, `[3]=p4`, `[4]=d1`, `[5]=d2`, `[6]=d3`.
- Parity: p1 = d0^d1^d3; p2 = d0^d2^d3; p4 = d1^d2^d3 (even parity, Hamming position order 1..7 = bits 0..6).
- Input handshake on `in_valid & in_ready`; output handshake on `cw_valid & cw_ready`.
- FSM, 3 states:
  - EMPTY: `cw_valid`=0, `in_ready`=1. On input accept, load enc(in_data[3:0]) into `codeword`, latch in_data[7:4] in the high-nibble register, go to LO.
  - LO: `cw_valid`=1, `in_ready`=0. On output handshake, load enc(high nibble), go to HI. Otherwise hold.
  - HI: `cw_valid`=1, `in_ready`=`cw_ready`. On output handshake with input accept, load enc(new low nibble), latch the new high nibble, go to LO. On output handshake without input, go to EMPTY. Otherwise hold.
- `codeword` and `cw_valid` are held stable while `cw_valid & !cw_ready`; the bench checks this.
- `cw_count` increments by 1 on every output handshake and wraps from 2^CNT_W-1 to 0.
- `in_ready` depends combinationally on `cw_ready` and state only, never on `in_valid`.

## Timing
- Reset, asynchronous: state EMPTY, `codeword`=0, `cw_valid`=0, `cw_count`=0, high-nibble register=0. `in_ready`=1 once reset is released.
- Latency: a byte accepted at edge N gives its low codeword valid after edge N and its high codeword valid after edge N+1, if `cw_ready` is held high.
- Throughput: 1 codeword per cycle sustained. That is 1 byte per 2 cycles with `in_valid` and `cw_ready` held high.
- Reset asserted mid-byte drops the pending high nibble. No partial codeword is emitted after reset.
- Backpressure in LO or HI stalls with no loss and no duplication.

## Configuration
- `HAMMING_ERR_INJECT_EN` defined:
  - The `inj_pos` port exists.
  - When a codeword is loaded into the output register, the bit at position `inj_pos` (bit index `inj_pos-1`) is inverted. `inj_pos` is sampled at load time.
  - 0 leaves the codeword unmodified.
- Undefined: no `inj_pos` port, and codewords are always the clean encoding.

## Test plan
- Reset then byte 0xB0 with `cw_ready`=1 -> `codeword` 0000000 (nibble 0x0), then 1010101 (nibble 0xB). `cw_count`=2. FSM returns to EMPTY.
- Back-to-back bytes 0x5A, 0xF0 with `in_valid`, `cw_ready` held high -> 1010010, 0101101, 0000000, 1111111 on consecutive cycles, no bubbles. `in_ready` high every other cycle.
- Byte 0xA5 with `cw_ready` low for 5 cycles after `cw_valid` rises -> `codeword` holds 0101101 and `in_ready` stays 0. Release gives 0101101 then 1010010.
- Assert `rst_n` low while in LO after accepting 0x3C -> all outputs zero immediately. Next byte 0x11 yields 0000111, 0000111 only.
- `CNT_W`=4, 9 bytes streamed -> `cw_count` reads 2 after 18 handshakes (wrap at 16).
- With `HAMMING_ERR_INJECT_EN`, `inj_pos`=3 and byte 0x00 -> 0000100, 0000100. Feeding these to the decoder recovers nibble 0x0 twice.

Source files
------------

// File: rtl/hamming_stream_encoder.sv
// Streaming Hamming(7,4) encoder: one byte in, two codewords out (low nibble first).
// Optional single-bit error injector on the inj_pos port, enabled by HAMMING_ERR_INJECT_EN.
module hamming_stream_encoder #(
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [7:0]       in_data,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [6:0]       codeword,
   output logic             cw_valid,
   input  logic             cw_ready,
`ifdef HAMMING_ERR_INJECT_EN
   input  logic [2:0]       inj_pos,
`endif
   output logic [CNT_W-1:0] cw_count
);

   typedef enum logic [1:0] {
      S_EMPTY,
      S_LO,
      S_HI
   } state_e;

   state_e           state_q;
   logic [3:0]       hi_nib_q;
   logic [6:0]       codeword_q;
   logic             cw_valid_q;
   logic [CNT_W-1:0] cnt_q;

   logic [6:0]       inj_mask;
   logic [6:0]       lo_cw_d;
   logic [6:0]       hi_cw_d;
   logic             in_accept;
   logic             out_hs;

   // Bit order matches Hamming positions 1..7: p1 p2 d0 p4 d1 d2 d3.
   function automatic logic [6:0] enc(input logic [3:0] d);
      return {d[3], d[2], d[1], d[1] ^ d[2] ^ d[3], d[0], d[0] ^ d[2] ^ d[3], d[0] ^ d[1] ^ d[3]};
   endfunction

   always_comb begin
      inj_mask = '0;
`ifdef HAMMING_ERR_INJECT_EN
      if (inj_pos != 3'd0) inj_mask = 7'(7'd1 << (inj_pos - 3'd1));
`endif
   end

   always_comb begin
      lo_cw_d = enc(in_data[3:0]) ^ inj_mask;
      hi_cw_d = enc(hi_nib_q) ^ inj_mask;
   end

   always_comb begin
      in_ready = 1'b0;
      case (state_q)
         S_EMPTY: in_ready = 1'b1;
         S_HI:    in_ready = cw_ready;
         default: in_ready = 1'b0;
      endcase
   end

   assign in_accept = in_valid & in_ready;
   assign out_hs    = cw_valid_q & cw_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_EMPTY;
         hi_nib_q   <= '0;
         codeword_q <= '0;
         cw_valid_q <= 1'b0;
         cnt_q      <= '0;
      end else begin
         if (out_hs) cnt_q <= cnt_q + CNT_W'(1);
         case (state_q)
            S_EMPTY: begin
               if (in_accept) begin
                  codeword_q <= lo_cw_d;
                  hi_nib_q   <= in_data[7:4];
                  cw_valid_q <= 1'b1;
                  state_q    <= S_LO;
               end
            end
            S_LO: begin
               if (out_hs) begin
                  codeword_q <= hi_cw_d;
                  state_q    <= S_HI;
               end
            end
            S_HI: begin
               // in_ready tracks cw_ready here, so an accept always coincides with a handoff.
               if (out_hs) begin
                  if (in_accept) begin
                     codeword_q <= lo_cw_d;
                     hi_nib_q   <= in_data[7:4];
                     state_q    <= S_LO;
                  end else begin
                     cw_valid_q <= 1'b0;
                     state_q    <= S_EMPTY;
                  end
               end
            end
            default: begin
               cw_valid_q <= 1'b0;
               state_q    <= S_EMPTY;
            end
         endcase
      end
   end

   assign codeword = codeword_q;
   assign cw_valid = cw_valid_q;
   assign cw_count = cnt_q;

endmodule
